// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit CPU datapath.
// Steps each instruction through fetch, decode, execute, memory and writeback.
module cpu_sequencer #(
  parameter int DataWidth  = 16,
  parameter int AddrWidth  = 8,
  parameter int WordSize   = 2,
  parameter int SelectSize = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DataWidth-1:0]  IR,
  input  logic                  ALU_Zero,
  input  logic                  Mem_Rdy,
  output logic                  PC_Ld,
  output logic [SelectSize-1:0] PC_Src,
  output logic                  IR_Ld,
  output logic [SelectSize-1:0] Addr_Src,
  output logic                  Mem_Rd,
  output logic                  Mem_Wr,
  output logic                  Reg_Wr,
  output logic [SelectSize-1:0] Reg_Src,
  output logic [1:0]            ALU_Op,
  output logic                  Retire,
  output logic                  Illegal,
  output logic                  Halted,
  output logic [2:0]            State
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [SelectSize-1:0] SelPc   = SelectSize'(0);
  localparam logic [SelectSize-1:0] SelIr   = SelectSize'(1);
  localparam logic [SelectSize-1:0] SelAlu  = SelectSize'(0);
  localparam logic [SelectSize-1:0] SelImm  = SelectSize'(1);
  localparam logic [SelectSize-1:0] SelMem  = SelectSize'(2);

  localparam logic [1:0] AluPass = 2'd0;
  localparam logic [1:0] AluAdd  = 2'd1;
  localparam logic [1:0] AluSub  = 2'd2;

  state_e state_q, state_d;

  logic [3:0] opcode;
  logic is_nop, is_ldi, is_ld, is_st;
  logic is_add, is_sub, is_beq, is_jmp;
  logic is_hlt, is_ill;
  logic [1:0] arith_op;

  assign opcode = IR[DataWidth-1 -: 4];

  assign is_nop = (opcode == 4'h0);
  assign is_ldi = (opcode == 4'h1);
  assign is_ld  = (opcode == 4'h2);
  assign is_st  = (opcode == 4'h3);
  assign is_add = (opcode == 4'h4);
  assign is_sub = (opcode == 4'h5);
  assign is_beq = (opcode == 4'h6);
  assign is_jmp = (opcode == 4'h7);
  assign is_hlt = (opcode == 4'hF);
  assign is_ill = opcode[3] & ~(&opcode);

  assign arith_op = is_sub ? AluSub : (is_add ? AluAdd : AluPass);

  // Operand/target fields are consumed by the datapath, not here.
  logic unused_cfg;
  assign unused_cfg = ^{IR[DataWidth-5:AddrWidth],
                        IR[AddrWidth-1:0],
                        2'(WordSize)};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    PC_Ld    = 1'b0;
    PC_Src   = SelPc;
    IR_Ld    = 1'b0;
    Addr_Src = SelPc;
    Mem_Rd   = 1'b0;
    Mem_Wr   = 1'b0;
    Reg_Wr   = 1'b0;
    Reg_Src  = SelAlu;
    ALU_Op   = AluPass;
    Retire   = 1'b0;
    Illegal  = 1'b0;
    Halted   = 1'b0;
    State    = state_q;

    unique case (state_q)
      FETCH: begin
        Addr_Src = SelPc;
        Mem_Rd   = 1'b1;
        if (Mem_Rdy) begin
          IR_Ld   = 1'b1;
          PC_Ld   = 1'b1;
          PC_Src  = SelPc;
          state_d = DECODE;
        end
      end

      DECODE: begin
        unique case (1'b1)
          is_nop: begin
            Retire  = 1'b1;
            state_d = FETCH;
          end
          is_ldi: state_d = WB;
          is_ld:  state_d = MEM;
          is_st:  state_d = MEM;
          is_add: state_d = EXEC;
          is_sub: state_d = EXEC;
          is_beq: state_d = EXEC;
          is_jmp: state_d = EXEC;
          is_hlt: begin
            Retire  = 1'b1;
            state_d = HALT;
          end
          is_ill: begin
            Illegal = 1'b1;
            Retire  = 1'b1;
            state_d = FETCH;
          end
          default: state_d = FETCH;
        endcase
      end

      EXEC: begin
        unique case (1'b1)
          is_add, is_sub: begin
            ALU_Op  = arith_op;
            state_d = WB;
          end
          is_beq: begin
            if (ALU_Zero) begin
              PC_Ld  = 1'b1;
              PC_Src = SelIr;
            end
            Retire  = 1'b1;
            state_d = FETCH;
          end
          is_jmp: begin
            PC_Ld   = 1'b1;
            PC_Src  = SelIr;
            Retire  = 1'b1;
            state_d = FETCH;
          end
          default: state_d = FETCH;
        endcase
      end

      MEM: begin
        Addr_Src = SelIr;
        unique case (1'b1)
          is_ld: begin
            Mem_Rd = 1'b1;
            if (Mem_Rdy) begin
              state_d = WB;
            end
          end
          is_st: begin
            Mem_Wr = 1'b1;
            if (Mem_Rdy) begin
              Retire  = 1'b1;
              state_d = FETCH;
            end
          end
          default: begin
            Addr_Src = SelPc;
            state_d  = FETCH;
          end
        endcase
      end

      WB: begin
        state_d = FETCH;
        unique case (1'b1)
          is_add, is_sub: begin
            Reg_Wr  = 1'b1;
            Reg_Src = SelAlu;
            ALU_Op  = arith_op;
            Retire  = 1'b1;
          end
          is_ldi: begin
            Reg_Wr  = 1'b1;
            Reg_Src = SelImm;
            Retire  = 1'b1;
          end
          is_ld: begin
            Reg_Wr  = 1'b1;
            Reg_Src = SelMem;
            Retire  = 1'b1;
          end
          default: ;
        endcase
      end

      HALT: begin
        Halted = 1'b1;
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    // Reset silences every strobe in the cycle it is asserted.
    if (Reset) begin
      state_d  = FETCH;
      PC_Ld    = 1'b0;
      PC_Src   = SelPc;
      IR_Ld    = 1'b0;
      Addr_Src = SelPc;
      Mem_Rd   = 1'b0;
      Mem_Wr   = 1'b0;
      Reg_Wr   = 1'b0;
      Reg_Src  = SelAlu;
      ALU_Op   = AluPass;
      Retire   = 1'b0;
      Illegal  = 1'b0;
      Halted   = 1'b0;
      State    = 3'd0;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: per-instruction expected cycle traces
// built from opcode timing rules, replayed with random memory waits.
module tb_cpu_sequencer;

  logic        Clk;
  logic        Reset;
  logic [15:0] IR;
  logic        ALU_Zero;
  logic        Mem_Rdy;
  logic        PC_Ld;
  logic [1:0]  PC_Src;
  logic        IR_Ld;
  logic [1:0]  Addr_Src;
  logic        Mem_Rd;
  logic        Mem_Wr;
  logic        Reg_Wr;
  logic [1:0]  Reg_Src;
  logic [1:0]  ALU_Op;
  logic        Retire;
  logic        Illegal;
  logic        Halted;
  logic [2:0]  State;

  cpu_sequencer dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .IR       (IR),
    .ALU_Zero (ALU_Zero),
    .Mem_Rdy  (Mem_Rdy),
    .PC_Ld    (PC_Ld),
    .PC_Src   (PC_Src),
    .IR_Ld    (IR_Ld),
    .Addr_Src (Addr_Src),
    .Mem_Rd   (Mem_Rd),
    .Mem_Wr   (Mem_Wr),
    .Reg_Wr   (Reg_Wr),
    .Reg_Src  (Reg_Src),
    .ALU_Op   (ALU_Op),
    .Retire   (Retire),
    .Illegal  (Illegal),
    .Halted   (Halted),
    .State    (State)
  );

  typedef struct packed {
    logic       pc_ld;
    logic [1:0] pc_src;
    logic       ir_ld;
    logic [1:0] addr_src;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic [1:0] reg_src;
    logic [1:0] alu_op;
    logic       retire;
    logic       illegal;
    logic       halted;
    logic [2:0] st;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        zero;
    logic [15:0] ir;
    out_t        o;
  } cyc_t;

  cyc_t q[$];
  int   n_chk;
  int   n_pass;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic cyc_t mk(input logic [15:0] ir);
    cyc_t c;
    c.rst  = 1'b0;
    c.rdy  = 1'($urandom);
    c.zero = 1'($urandom);
    c.ir   = ir;
    c.o    = '0;
    return c;
  endfunction

  task automatic add_rst(input logic [15:0] ir, input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = mk(ir);
      c.rst = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic add_wb(input logic [15:0] ir,
                        input logic [1:0] src,
                        input logic [1:0] alu);
    cyc_t c;
    c = mk(ir);
    c.o.st      = 3'd4;
    c.o.reg_wr  = 1'b1;
    c.o.reg_src = src;
    c.o.alu_op  = alu;
    c.o.retire  = 1'b1;
    q.push_back(c);
  endtask

  task automatic add_mem(input logic [15:0] ir, input int nm, input bit wr);
    cyc_t c;
    for (int i = 0; i <= nm; i++) begin
      c = mk(ir);
      c.rdy        = (i == nm);
      c.o.st       = 3'd3;
      c.o.addr_src = 2'd1;
      if (wr) c.o.mem_wr = 1'b1;
      else    c.o.mem_rd = 1'b1;
      if (wr && i == nm) c.o.retire = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic add_halt(input logic [15:0] ir, input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = mk(ir);
      c.rdy      = i[0];
      c.o.st     = 3'd5;
      c.o.halted = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic add_instr(input logic [15:0] ir,
                           input int nf, input int nm, input bit z);
    cyc_t c;
    logic [3:0] op;
    op = ir[15:12];
    for (int i = 0; i <= nf; i++) begin
      c = mk(ir);
      c.rdy      = (i == nf);
      c.o.mem_rd = 1'b1;
      if (i == nf) begin
        c.o.ir_ld = 1'b1;
        c.o.pc_ld = 1'b1;
      end
      q.push_back(c);
    end
    c = mk(ir);
    c.o.st = 3'd1;
    if (op == 4'h0 || op == 4'hF) c.o.retire = 1'b1;
    if (op >= 4'h8 && op <= 4'hE) begin
      c.o.illegal = 1'b1;
      c.o.retire  = 1'b1;
    end
    q.push_back(c);
    case (op)
      4'h1: add_wb(ir, 2'd1, 2'd0);
      4'h2: begin
        add_mem(ir, nm, 1'b0);
        add_wb(ir, 2'd2, 2'd0);
      end
      4'h3: add_mem(ir, nm, 1'b1);
      4'h4, 4'h5: begin
        c = mk(ir);
        c.o.st     = 3'd2;
        c.o.alu_op = 2'(op - 4'd3);
        q.push_back(c);
        add_wb(ir, 2'd0, 2'(op - 4'd3));
      end
      4'h6: begin
        c = mk(ir);
        c.zero     = z;
        c.o.st     = 3'd2;
        c.o.pc_ld  = z;
        c.o.pc_src = z ? 2'd1 : 2'd0;
        c.o.retire = 1'b1;
        q.push_back(c);
      end
      4'h7: begin
        c = mk(ir);
        c.o.st     = 3'd2;
        c.o.pc_ld  = 1'b1;
        c.o.pc_src = 2'd1;
        c.o.retire = 1'b1;
        q.push_back(c);
      end
      default: ;
    endcase
  endtask

  initial begin
    int          start;
    int          len;
    int          kk;
    logic [15:0] ir;
    out_t        ob;
    n_chk    = 0;
    n_pass   = 0;
    Reset    = 1'b1;
    Mem_Rdy  = 1'b1;
    ALU_Zero = 1'b0;
    IR       = 16'h0;

    add_rst(16'h0000, 2);
    q[0].rdy = 1'b1;
    q[1].rdy = 1'b1;
    add_instr(16'h4000, 0, 0, 1'b0);
    add_instr(16'h2010, 0, 3, 1'b0);
    add_instr(16'h6020, 0, 0, 1'b0);
    add_instr(16'h6020, 0, 0, 1'b1);
    start = q.size();
    add_instr(16'h3005, 0, 4, 1'b0);
    while (q.size() > start + 4) void'(q.pop_back());
    add_rst(16'h3005, 1);
    add_instr(16'h9000, 0, 0, 1'b0);
    add_instr(16'hF000, 0, 0, 1'b0);
    add_halt(16'hF000, 10);
    add_rst(16'hF000, 1);
    add_instr(16'h1055, 1, 0, 1'b0);
    add_instr(16'h7033, 2, 0, 1'b0);
    add_instr(16'h5000, 0, 0, 1'b0);
    add_instr(16'h0000, 0, 0, 1'b0);

    for (int k = 0; k < 150; k++) begin
      ir    = 16'($urandom);
      start = q.size();
      add_instr(ir, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom));
      if (ir[15:12] == 4'hF) begin
        add_halt(ir, $urandom_range(1, 6));
        add_rst(ir, 1);
      end else if ($urandom_range(0, 9) == 0) begin
        len = q.size() - start;
        kk  = $urandom_range(1, len - 1);
        while (q.size() > start + kk) void'(q.pop_back());
        add_rst(ir, $urandom_range(1, 2));
      end
    end

    for (int i = 0; i < q.size(); i++) begin
      @(posedge Clk);
      #1;
      Reset    = q[i].rst;
      Mem_Rdy  = q[i].rdy;
      ALU_Zero = q[i].zero;
      IR       = q[i].ir;
      @(negedge Clk);
      ob.pc_ld    = PC_Ld;
      ob.pc_src   = PC_Src;
      ob.ir_ld    = IR_Ld;
      ob.addr_src = Addr_Src;
      ob.mem_rd   = Mem_Rd;
      ob.mem_wr   = Mem_Wr;
      ob.reg_wr   = Reg_Wr;
      ob.reg_src  = Reg_Src;
      ob.alu_op   = ALU_Op;
      ob.retire   = Retire;
      ob.illegal  = Illegal;
      ob.halted   = Halted;
      ob.st       = State;
      check($sformatf("cyc%0d", i), {13'b0, ob}, {13'b0, q[i].o});
      check("rdwr", {31'b0, Mem_Rd & Mem_Wr}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
